// File: rtl/erv25_pkg.sv
// Shared types and encodings for the ERV25 pipeline control blocks.
package erv25_pkg;

    localparam int REG_AW_DEF = 5;

    // Operand source selects for stage R
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_E  = 2'b01;
    localparam logic [1:0] FWD_W  = 2'b10;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_BR_FLUSH = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter with synchronous clear.
module hazard_perf_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // Count events, stick at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, stall, flush and forwarding control for the ERV25 5-stage pipeline.
//
//  state       | meaning
//  ------------+---------------------------------------------------------
//  ST_RUN      | normal issue; RAW hazards resolved by forward or stall
//  ST_BR_FLUSH | flushing F_D/D_R for the remainder of a branch window
module pipeline_hazard_ctrl
    import erv25_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEF,
    parameter int FWD_EN     = 1,
    parameter int BR_FLUSH_N = 1,
    parameter int BUSY_TMO   = 64,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_R,
    input  logic [REG_AW-1:0] rs2_R,
    input  logic              rs1_use_R,
    input  logic              rs2_use_R,
    input  logic [REG_AW-1:0] rd_E,
    input  logic              reg_flag_E,
    input  logic              mem_read_E,
    input  logic [REG_AW-1:0] rd_W,
    input  logic              reg_flag_W,
    input  logic              branch_E,
    input  logic              ex_busy,
    output logic              enable_F_D,
    output logic              enable_D_R,
    output logic              enable_R_E,
    output logic              enable_E_W,
    output logic              flush_F_D,
    output logic              flush_D_R,
    output logic              flush_R_E,
    output logic              flush_E_W,
    output logic [1:0]        fwd_sel_rs1,
    output logic [1:0]        fwd_sel_rs2,
    output logic              busy_timeout,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int             BR_CW     = 3;
    localparam logic [BR_CW-1:0] BR_RELOAD = BR_CW'(BR_FLUSH_N - 1);
    localparam int             WD_W      = $clog2(BUSY_TMO + 1);
    localparam logic [WD_W-1:0] WD_RELOAD = WD_W'(BUSY_TMO);

    ctrl_state_t      state_q, state_nxt;
    logic [BR_CW-1:0] br_cnt_q, br_cnt_nxt;
    logic [WD_W-1:0]  wd_cnt_q;
    logic             flush_inc;
    logic             stall_inc;

    logic hit_e1, hit_e2, hit_w1, hit_w2;
    logic fwd_e_ok;
    logic stall1, stall2;
    logic [1:0] sel1, sel2;

    assign hit_e1 = rs1_use_R && (rs1_R != '0) && reg_flag_E && (rs1_R == rd_E);
    assign hit_e2 = rs2_use_R && (rs2_R != '0) && reg_flag_E && (rs2_R == rd_E);
    assign hit_w1 = rs1_use_R && (rs1_R != '0) && reg_flag_W && (rs1_R == rd_W);
    assign hit_w2 = rs2_use_R && (rs2_R != '0) && reg_flag_W && (rs2_R == rd_W);

    // A load result is not available in E, so it can only be waited for
    assign fwd_e_ok = (FWD_EN != 0) && !mem_read_E;

    // E match shadows a W match for the same operand
    assign stall1 = hit_e1 ? !fwd_e_ok : (hit_w1 && (FWD_EN == 0));
    assign stall2 = hit_e2 ? !fwd_e_ok : (hit_w2 && (FWD_EN == 0));
    assign sel1   = (hit_e1 && fwd_e_ok) ? FWD_E :
                    ((!hit_e1 && hit_w1 && (FWD_EN != 0)) ? FWD_W : FWD_RF);
    assign sel2   = (hit_e2 && fwd_e_ok) ? FWD_E :
                    ((!hit_e2 && hit_w2 && (FWD_EN != 0)) ? FWD_W : FWD_RF);

    // Branch-window state and down-counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            br_cnt_q <= '0;
        end else begin
            state_q  <= state_nxt;
            br_cnt_q <= br_cnt_nxt;
        end
    end

    // Priority: reset > busy freeze > branch/window > RAW resolution
    always_comb begin
        enable_F_D  = 1'b1;
        enable_D_R  = 1'b1;
        enable_R_E  = 1'b1;
        enable_E_W  = 1'b1;
        flush_F_D   = 1'b0;
        flush_D_R   = 1'b0;
        flush_R_E   = 1'b0;
        flush_E_W   = 1'b0;
        fwd_sel_rs1 = FWD_RF;
        fwd_sel_rs2 = FWD_RF;
        state_nxt   = state_q;
        br_cnt_nxt  = br_cnt_q;
        flush_inc   = 1'b0;

        if (rst) begin
            flush_F_D = 1'b1;
            flush_D_R = 1'b1;
            flush_R_E = 1'b1;
            flush_E_W = 1'b1;
        end else if (ex_busy) begin
            enable_F_D = 1'b0;
            enable_D_R = 1'b0;
            enable_R_E = 1'b0;
            flush_E_W  = 1'b1;
        end else if (branch_E) begin
            flush_F_D = 1'b1;
            flush_D_R = 1'b1;
            flush_inc = 1'b1;
            if (BR_FLUSH_N > 1) begin
                state_nxt  = ST_BR_FLUSH;
                br_cnt_nxt = BR_RELOAD;
            end
        end else if (state_q == ST_BR_FLUSH) begin
            flush_F_D  = 1'b1;
            flush_D_R  = 1'b1;
            br_cnt_nxt = br_cnt_q - 1'b1;
            if (br_cnt_q == BR_CW'(1)) begin
                state_nxt = ST_RUN;
            end
        end else begin
            fwd_sel_rs1 = sel1;
            fwd_sel_rs2 = sel2;
            if (stall1 || stall2) begin
                enable_F_D = 1'b0;
                enable_D_R = 1'b0;
                flush_R_E  = 1'b1;
            end
        end
    end

    // Watchdog: down-counts consecutive busy cycles, terminal count sets the sticky flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q     <= WD_RELOAD;
            busy_timeout <= 1'b0;
        end else if (ex_busy) begin
            if (wd_cnt_q != '0) begin
                wd_cnt_q <= wd_cnt_q - 1'b1;
            end
            if (wd_cnt_q == WD_W'(1)) begin
                busy_timeout <= 1'b1;
            end
        end else begin
            wd_cnt_q <= WD_RELOAD;
        end
    end

    assign stall_inc = !enable_F_D && !rst;

    hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

    hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .cnt (flush_cnt)
    );

endmodule
